// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_cfg
//
// Parametrised UART receiver: DATA_BITS (5..9) data bits, optional odd/even
// parity, 1 or 2 stop bits. The line is double-flopped, each bit is decided
// by a 3-sample majority vote around mid-bit, and a start bit that votes high
// is dropped as a glitch. Each completed frame produces a one-clock po_flag
// together with the received word and its error flags.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   rx             in   asynchronous serial line, idle high
//   po_data        out  received word, LSB = first data bit on the line
//   po_flag        out  one-clock pulse, po_data and error flags valid
//   po_parity_err  out  parity mismatch (always 0 when PARITY = 0)
//   po_frame_err   out  at least one stop bit voted low
//   po_break       out  start, data, parity and every stop bit voted low
//   busy           out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_flag,
    output logic                 po_parity_err,
    output logic                 po_frame_err,
    output logic                 po_break,
    output logic                 busy
);

    localparam int CNT_BAUD_MAX = CLK_FREQ / BAUD - 1;
    localparam int CNT_HALF     = CNT_BAUD_MAX / 2;
    localparam int CW           = (CNT_BAUD_MAX > 1) ? $clog2(CNT_BAUD_MAX + 1) : 1;
    localparam int BW           = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_MAX_C  = CW'(CNT_BAUD_MAX);
    localparam logic [CW-1:0] CNT_SMP0_C = CW'(CNT_HALF - 1);
    localparam logic [CW-1:0] CNT_SMP1_C = CW'(CNT_HALF);
    localparam logic [CW-1:0] CNT_DEC_C  = CW'(CNT_HALF + 1);
    localparam logic [BW-1:0] BIT_LAST_C = BW'(DATA_BITS - 1);
    localparam logic          HAS_PAR_C  = (PARITY != 0);
    localparam logic          ODD_PAR_C  = (PARITY == 1);
    localparam logic          TWO_STOP_C = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Expected parity bit for a data word: XOR for even, inverted XOR for odd.
    function automatic logic exp_parity(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Input path
    logic sync1_q;
    logic rx_s_q;
    logic rx_d_q;

    // FSM and datapath state
    state_t                 state_q,     state_d;
    logic [CW-1:0]          cnt_q,       cnt_d;
    logic [BW-1:0]          bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,     shift_d;
    logic                   smp0_q,      smp0_d;
    logic                   smp1_q,      smp1_d;
    logic                   par_err_q,   par_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   brk_q,       brk_d;

    // Output registers
    logic [DATA_BITS-1:0]   po_data_q;
    logic                   po_flag_q;
    logic                   po_parity_err_q;
    logic                   po_frame_err_q;
    logic                   po_break_q;
    logic                   busy_q;

    logic start_edge_s;
    logic wrap_s;
    logic decide_s;
    logic vote_s;
    logic last_bit_s;
    logic done_s;

    // A start edge is a high-to-low step between the delayed and synchronised line.
    assign start_edge_s = rx_d_q & ~rx_s_q;
    assign wrap_s       = (cnt_q == CNT_MAX_C);
    assign decide_s     = (cnt_q == CNT_DEC_C);
    // The third sample is the live synchronised line at the decision count.
    assign vote_s       = maj3(smp0_q, smp1_q, rx_s_q);
    assign last_bit_s   = (bit_cnt_q == BIT_LAST_C);

    // Two-flop synchroniser plus one delay flop for edge detection; resets high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            bit_cnt_q   <= {BW{1'b0}};
            shift_q     <= {DATA_BITS{1'b0}};
            smp0_q      <= 1'b1;
            smp1_q      <= 1'b1;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            smp0_q      <= smp0_d;
            smp1_q      <= smp1_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            brk_q       <= brk_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                // A start bit that votes high was a glitch; drop it mid-bit.
                if (decide_s && vote_s) begin
                    state_d = S_IDLE;
                end else if (wrap_s) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (wrap_s && last_bit_s) begin
                    state_d = HAS_PAR_C ? S_PARITY : S_STOP1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (wrap_s) begin
                    state_d = S_STOP1;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP1: begin
                // With one stop bit the frame ends at mid-stop, leaving half a
                // bit of slack for the next start edge.
                if (decide_s && !TWO_STOP_C) begin
                    state_d = S_IDLE;
                end else if (wrap_s && TWO_STOP_C) begin
                    state_d = S_STOP2;
                end else begin
                    state_d = S_STOP1;
                end
            end
            S_STOP2: begin
                if (decide_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STOP2;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: baud counter, samples, shift register, error tracking.
    always_comb begin
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        smp0_d      = smp0_q;
        smp1_d      = smp1_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        brk_d       = brk_q;
        done_s      = 1'b0;

        // Counter is held at zero while idle and also when about to go idle, so a
        // start edge seen on the first idle cycle begins a bit at count zero.
        if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
            cnt_d = {CW{1'b0}};
        end else if (wrap_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (cnt_q == CNT_SMP0_C) begin
            smp0_d = rx_s_q;
        end else begin
            smp0_d = smp0_q;
        end

        if (cnt_q == CNT_SMP1_C) begin
            smp1_d = rx_s_q;
        end else begin
            smp1_d = smp1_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge_s) begin
                    bit_cnt_d   = {BW{1'b0}};
                    shift_d     = {DATA_BITS{1'b0}};
                    par_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    brk_d       = 1'b1;
                end else begin
                    bit_cnt_d   = bit_cnt_q;
                end
            end
            S_START: begin
                if (decide_s) begin
                    brk_d = brk_q & ~vote_s;
                end else begin
                    brk_d = brk_q;
                end
            end
            S_DATA: begin
                // LSB arrives first, so shift in from the top.
                if (decide_s) begin
                    shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
                    brk_d   = brk_q & ~vote_s;
                end else begin
                    shift_d = shift_q;
                end
                if (wrap_s) begin
                    bit_cnt_d = last_bit_s ? {BW{1'b0}} : (bit_cnt_q + 1'b1);
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            S_PARITY: begin
                if (decide_s) begin
                    par_err_d = vote_s ^ exp_parity(shift_q, ODD_PAR_C);
                    brk_d     = brk_q & ~vote_s;
                end else begin
                    par_err_d = par_err_q;
                end
            end
            S_STOP1, S_STOP2: begin
                if (decide_s) begin
                    frame_err_d = frame_err_q | ~vote_s;
                    brk_d       = brk_q & ~vote_s;
                    done_s      = (state_q == S_STOP2) || !TWO_STOP_C;
                end else begin
                    frame_err_d = frame_err_q;
                end
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    // Output registers: word and flags load together with the one-clock pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            po_data_q       <= {DATA_BITS{1'b0}};
            po_flag_q       <= 1'b0;
            po_parity_err_q <= 1'b0;
            po_frame_err_q  <= 1'b0;
            po_break_q      <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            po_flag_q <= done_s;
            busy_q    <= (state_d != S_IDLE);
            if (done_s) begin
                po_data_q       <= shift_q;
                po_parity_err_q <= par_err_q;
                // Final stop decision is folded in from the next-value path.
                po_frame_err_q  <= frame_err_d;
                po_break_q      <= brk_d;
            end else begin
                po_data_q       <= po_data_q;
                po_parity_err_q <= po_parity_err_q;
                po_frame_err_q  <= po_frame_err_q;
                po_break_q      <= po_break_q;
            end
        end
    end

    assign po_data       = po_data_q;
    assign po_flag       = po_flag_q;
    assign po_parity_err = po_parity_err_q;
    assign po_frame_err  = po_frame_err_q;
    assign po_break      = po_break_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// Testbench for uart_rx_cfg: four receivers with different frame formats share
// one clock and reset, each with its own serial line. Received frames are
// captured into per-receiver queues and compared against a frame-level model.
module tb_uart_rx_cfg;

    localparam int BIT_A = 434;   // 50 MHz / 115200
    localparam int BIT_D = 16;    // 1 MHz / 62500

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       br;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rx_line;

    logic [7:0] da, db, dc;
    logic [8:0] dd;
    logic fa, pa, ea, ka, ba;
    logic fb, pb, eb, kb, bb;
    logic fc, pc, ec, kc, bc;
    logic fd, pd, ed, kd, bd;

    rec_t qa[$];
    rec_t qb[$];
    rec_t qc[$];
    rec_t qd[$];

    int total = 0;
    int bad   = 0;

    // 50 MHz system clock.
    always #10 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(50000000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .rx(rx_line[0]), .po_data(da), .po_flag(fa),
        .po_parity_err(pa), .po_frame_err(ea), .po_break(ka), .busy(ba));
    uart_rx_cfg #(.CLK_FREQ(50000000), .BAUD(115200), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .rx(rx_line[1]), .po_data(db), .po_flag(fb),
        .po_parity_err(pb), .po_frame_err(eb), .po_break(kb), .busy(bb));
    uart_rx_cfg #(.CLK_FREQ(50000000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .rx(rx_line[2]), .po_data(dc), .po_flag(fc),
        .po_parity_err(pc), .po_frame_err(ec), .po_break(kc), .busy(bc));
    uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD(62500), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u_d (
        .clk(clk), .rst(rst), .rx(rx_line[3]), .po_data(dd), .po_flag(fd),
        .po_parity_err(pd), .po_frame_err(ed), .po_break(kd), .busy(bd));

    // Capture receiver A frames.
    always @(negedge clk) if (fa === 1'b1) qa.push_back({1'b0, da, pa, ea, ka});
    // Capture receiver B frames.
    always @(negedge clk) if (fb === 1'b1) qb.push_back({1'b0, db, pb, eb, kb});
    // Capture receiver C frames.
    always @(negedge clk) if (fc === 1'b1) qc.push_back({1'b0, dc, pc, ec, kc});
    // Capture receiver D frames.
    always @(negedge clk) if (fd === 1'b1) qd.push_back({dd, pd, ed, kd});

    // Line levels of one frame, index 0 = start bit.
    function automatic logic [12:0] build(input int nd, input int pm, input int ns,
                                          input logic [8:0] data, input logic flip,
                                          input logic [1:0] stop_low);
        logic [12:0] lv;
        logic        par;
        int          pos;
        lv  = '0;
        par = 1'b0;
        for (int i = 0; i < nd; i++) begin
            lv[1+i] = data[i];
            par     = par ^ data[i];
        end
        pos = 1 + nd;
        if (pm != 0) begin
            if (pm == 1) par = ~par;
            lv[pos] = par ^ flip;
            pos++;
        end
        for (int s = 0; s < ns; s++) lv[pos+s] = ~stop_low[s];
        return lv;
    endfunction

    // What a receiver should report for a frame, from its line levels alone.
    function automatic rec_t model(input int nd, input int pm, input int ns, input logic [12:0] lv);
        rec_t r;
        int   ones;
        int   pos;
        r    = '0;
        ones = 0;
        for (int i = 0; i < nd; i++) begin
            r.d[i] = lv[1+i];
            ones  += int'(lv[1+i]);
        end
        pos = 1 + nd;
        if (pm != 0) begin
            ones += int'(lv[pos]);
            r.pe  = (pm == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            pos++;
        end
        for (int s = 0; s < ns; s++) if (lv[pos+s] == 1'b0) r.fe = 1'b1;
        r.br = 1'b1;
        for (int i = 0; i < pos + ns; i++) if (lv[i] == 1'b1) r.br = 1'b0;
        return r;
    endfunction

    task automatic send_lv(input int idx, input int bclk, input int n, input logic [12:0] lv);
        for (int i = 0; i < n; i++) begin
            rx_line[idx] = lv[i];
            repeat (bclk) @(negedge clk);
        end
        rx_line[idx] = 1'b1;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        rx_line = 4'hF;
        repeat (4) @(negedge clk);
        total++;
        if ({da, fa, pa, ea, ka, ba} !== 13'h0)
            begin bad++; $display("FAIL reset_a got=%h exp=0", {da, fa, pa, ea, ka, ba}); end
        total++;
        if ({db, fb, pb, eb, kb, bb} !== 13'h0)
            begin bad++; $display("FAIL reset_b got=%h exp=0", {db, fb, pb, eb, kb, bb}); end
        total++;
        if ({dc, fc, pc, ec, kc, bc} !== 13'h0)
            begin bad++; $display("FAIL reset_c got=%h exp=0", {dc, fc, pc, ec, kc, bc}); end
        total++;
        if ({dd, fd, pd, ed, kd, bd} !== 14'h0)
            begin bad++; $display("FAIL reset_d got=%h exp=0", {dd, fd, pd, ed, kd, bd}); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if ({ba, bb, bc, bd} !== 4'h0 || (qa.size() + qb.size() + qc.size() + qd.size()) != 0)
            begin bad++; $display("FAIL idle_after_reset busy=%b frames=%0d exp busy=0 frames=0",
                                  {ba, bb, bc, bd}, qa.size() + qb.size() + qc.size() + qd.size()); end
    endtask

    task automatic test_basic;
        logic [12:0] lv;
        rec_t        exp;
        qa.delete();
        lv  = build(8, 0, 1, 9'h0A5, 1'b0, 2'b00);
        exp = model(8, 0, 1, lv);
        send_lv(0, BIT_A, 10, lv);
        repeat (10) @(negedge clk);
        total++;
        if (qa.size() != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", qa.size()); end
        else if (qa[0] !== exp) begin bad++; $display("FAIL basic_frame got=%h exp=%h", qa[0], exp); end
        total++;
        if (ba !== 1'b0 || da !== 8'hA5)
            begin bad++; $display("FAIL basic_hold busy=%b data=%h exp busy=0 data=a5", ba, da); end
    endtask

    task automatic test_back_to_back;
        logic [12:0] lv0, lv1;
        rec_t        exp[2];
        qa.delete();
        lv0    = build(8, 0, 1, 9'h000, 1'b0, 2'b00);
        lv1    = build(8, 0, 1, 9'h0FF, 1'b0, 2'b00);
        exp[0] = model(8, 0, 1, lv0);
        exp[1] = model(8, 0, 1, lv1);
        send_lv(0, BIT_A, 10, lv0);
        send_lv(0, BIT_A, 10, lv1);
        repeat (20) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (k >= qa.size()) begin bad++; $display("FAIL b2b_missing frame=%0d got=%0d frames", k, qa.size()); end
            else if (qa[k] !== exp[k]) begin bad++; $display("FAIL b2b_frame%0d got=%h exp=%h", k, qa[k], exp[k]); end
        end
    endtask

    task automatic test_parity;
        logic [12:0] lv;
        rec_t        exp;
        for (int f = 0; f < 2; f++) begin
            qb.delete();
            lv  = build(8, 2, 1, 9'h037, f[0], 2'b00);
            exp = model(8, 2, 1, lv);
            send_lv(1, BIT_A, 11, lv);
            repeat (10) @(negedge clk);
            total++;
            if (qb.size() != 1) begin bad++; $display("FAIL parity%0d_count got=%0d exp=1", f, qb.size()); end
            else if (qb[0] !== exp) begin bad++; $display("FAIL parity%0d_frame got=%h exp=%h", f, qb[0], exp); end
        end
        total++;
        if (pb !== 1'b1 || db !== 8'h37)
            begin bad++; $display("FAIL parity_err_out got pe=%b data=%h exp pe=1 data=37", pb, db); end
    endtask

    task automatic test_stop2;
        logic [12:0] lv;
        rec_t        exp;
        qc.delete();
        lv  = build(8, 0, 2, 9'h05A, 1'b0, 2'b10);
        exp = model(8, 0, 2, lv);
        send_lv(2, BIT_A, 12, lv);
        repeat (BIT_A) @(negedge clk);
        total++;
        if (qc.size() != 1) begin bad++; $display("FAIL stop2_count got=%0d exp=1", qc.size()); end
        else if (qc[0] !== exp) begin bad++; $display("FAIL stop2_frame got=%h exp=%h", qc[0], exp); end
    endtask

    task automatic test_break;
        rec_t exp;
        qa.delete();
        exp = model(8, 0, 1, 13'h0);
        rx_line[0] = 1'b0;
        repeat (20 * BIT_A) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (5 * BIT_A) @(negedge clk);
        total++;
        if (qa.size() != 1) begin bad++; $display("FAIL break_count got=%0d exp=1", qa.size()); end
        else if (qa[0] !== exp) begin bad++; $display("FAIL break_frame got=%h exp=%h", qa[0], exp); end
        total++;
        if (ba !== 1'b0) begin bad++; $display("FAIL break_busy got=%b exp=0", ba); end
    endtask

    task automatic test_glitch;
        qa.delete();
        rx_line[0] = 1'b0;
        repeat (100) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (50) @(negedge clk);
        total++;
        if (ba !== 1'b1) begin bad++; $display("FAIL glitch_busy_start got=%b exp=1", ba); end
        repeat (90) @(negedge clk);
        total++;
        if (ba !== 1'b0) begin bad++; $display("FAIL glitch_busy_drop got=%b exp=0", ba); end
        repeat (3 * BIT_A) @(negedge clk);
        total++;
        if (qa.size() != 0) begin bad++; $display("FAIL glitch_flag got=%0d frames exp=0", qa.size()); end
    endtask

    task automatic test_reset_abort;
        logic [12:0] lv;
        rec_t        exp;
        // A frame with a bad stop bit leaves non-zero outputs for reset to clear.
        qa.delete();
        lv  = build(8, 0, 1, 9'h096, 1'b0, 2'b01);
        exp = model(8, 0, 1, lv);
        send_lv(0, BIT_A, 10, lv);
        repeat (BIT_A) @(negedge clk);
        total++;
        if (qa.size() != 1) begin bad++; $display("FAIL stopbad_count got=%0d exp=1", qa.size()); end
        else if (qa[0] !== exp) begin bad++; $display("FAIL stopbad_frame got=%h exp=%h", qa[0], exp); end
        // Abort 0xF5 halfway through data bit 4; the rest of the frame stays high.
        qa.delete();
        lv = build(8, 0, 1, 9'h0F5, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            rx_line[0] = lv[i];
            repeat (BIT_A) @(negedge clk);
        end
        rx_line[0] = lv[5];
        repeat (BIT_A / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({da, fa, pa, ea, ka, ba} !== 13'h0)
            begin bad++; $display("FAIL abort_outputs got=%h exp=0", {da, fa, pa, ea, ka, ba}); end
        rst = 1'b0;
        repeat (BIT_A - BIT_A / 2 - 1) @(negedge clk);
        for (int i = 6; i < 10; i++) begin
            rx_line[0] = lv[i];
            repeat (BIT_A) @(negedge clk);
        end
        rx_line[0] = 1'b1;
        repeat (2 * BIT_A) @(negedge clk);
        total++;
        if (qa.size() != 0 || ba !== 1'b0)
            begin bad++; $display("FAIL abort_flag got frames=%0d busy=%b exp frames=0 busy=0", qa.size(), ba); end
        // Clean frame after the abort.
        lv  = build(8, 0, 1, 9'h03C, 1'b0, 2'b00);
        exp = model(8, 0, 1, lv);
        send_lv(0, BIT_A, 10, lv);
        repeat (10) @(negedge clk);
        total++;
        if (qa.size() != 1) begin bad++; $display("FAIL after_abort_count got=%0d exp=1", qa.size()); end
        else if (qa[0] !== exp) begin bad++; $display("FAIL after_abort_frame got=%h exp=%h", qa[0], exp); end
    endtask

    task automatic test_random;
        logic [12:0] lv;
        rec_t        exp;
        logic [1:0]  stop_low;
        logic        flip;
        for (int f = 0; f < 30; f++) begin
            qd.delete();
            if ((f % 10) == 7) begin
                lv = 13'h0;
            end else begin
                flip     = ($urandom_range(0, 3) == 0);
                stop_low = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                lv       = build(9, 1, 2, 9'($urandom_range(0, 511)), flip, stop_low);
            end
            exp = model(9, 1, 2, lv);
            send_lv(3, BIT_D, 13, lv);
            repeat (BIT_D + $urandom_range(0, 16)) @(negedge clk);
            total++;
            if (qd.size() != 1) begin bad++; $display("FAIL random%0d_count got=%0d exp=1", f, qd.size()); end
            else if (qd[0] !== exp) begin bad++; $display("FAIL random%0d_frame got=%h exp=%h", f, qd[0], exp); end
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_break();
        test_glitch();
        test_reset_abort();
        test_parity();
        test_stop2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
